// File: rtl/vga_host_writer.sv
// vga_host_writer: buffered host-bus master in front of the text-mode VGA
// controller. System bytes are queued in a FIFO and replayed one per host_cs
// strobe while the controller reports host_busy = 0.
// Optional feature: define HOST_WR_OVF_EN to add the sticky `ovf` flag/port.
module vga_host_writer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned SETUP_LEN  = 2,
  parameter int unsigned STROBE_LEN = 4
) (
  input  logic                          gen,
  input  logic                          host_reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_ad,
  input  logic [7:0]                    in_data,
  input  logic                          host_busy,
  output logic                          host_cs,
  output logic                          host_ad,
  output logic [7:0]                    host_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          idle
`ifdef HOST_WR_OVF_EN
  ,
  output logic                          ovf
`endif
);

  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_MAX = (SETUP_LEN > STROBE_LEN) ? SETUP_LEN : STROBE_LEN;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_STALL,
    S_HOLD
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            busy_q;
  logic            load;
  logic            cs_next;

  logic [8:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     level_next;
  logic            push, pop;
  logic [8:0]      head;

  assign in_ready = (fifo_level != (PW+1)'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == S_HOLD);
  assign head     = mem[rd_ptr];

  // Register host_busy once; the controller changes it on the falling edge.
  always_ff @(posedge gen or posedge host_reset) begin
    if (host_reset) busy_q <= 1'b0;
    else            busy_q <= host_busy;
  end

  // FIFO storage; contents need no reset since level/pointers gate access.
  always_ff @(posedge gen) begin
    if (push) mem[wr_ptr] <= {in_ad, in_data};
  end

  // Next FIFO occupancy; a full FIFO refuses pushes even when popping.
  always_comb begin
    level_next = fifo_level;
    if (push && !pop)      level_next = fifo_level + (PW+1)'(1);
    else if (pop && !push) level_next = fifo_level - (PW+1)'(1);
  end

  // FIFO pointers and level.
  always_ff @(posedge gen or posedge host_reset) begin
    if (host_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_level <= level_next;
    end
  end

  // Strobe sequencer: next state, counter, head load and strobe level.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fifo_level != '0 && !busy_q) begin
          state_next = S_SETUP;
          cnt_next   = '0;
          load       = 1'b1;
        end
      end
      S_SETUP: begin
        if (busy_q) begin
          state_next = S_IDLE;
        end else if (cnt == CW'(SETUP_LEN - 1)) begin
          state_next = S_STROBE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_STROBE: begin
        if (busy_q) begin
          state_next = S_STALL;
        end else if (cnt == CW'(STROBE_LEN - 1)) begin
          state_next = S_HOLD;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_STALL: begin
        // A stalled strobe restarts with a full count so the low width
        // before the rising edge is always STROBE_LEN busy-free cycles.
        if (!busy_q) begin
          state_next = S_STROBE;
          cnt_next   = '0;
        end
      end
      S_HOLD: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    cs_next = !(state_next == S_STROBE || state_next == S_STALL);
  end

  // Sequencer state and registered bus outputs.
  always_ff @(posedge gen or posedge host_reset) begin
    if (host_reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      host_cs   <= 1'b1;
      host_ad   <= 1'b0;
      host_data <= '0;
      idle      <= 1'b1;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      host_cs <= cs_next;
      idle    <= (state_next == S_IDLE) && (level_next == '0);
      if (load) begin
        host_ad   <= head[8];
        host_data <= head[7:0];
      end
    end
  end

`ifdef HOST_WR_OVF_EN
  // Sticky overflow: any offered byte while the FIFO is full.
  always_ff @(posedge gen or posedge host_reset) begin
    if (host_reset)                ovf <= 1'b0;
    else if (in_valid && !in_ready) ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_vga_host_writer.sv
// Directed self-checking bench for vga_host_writer (defaults 16/2/4).
module tb_vga_host_writer;

  logic       gen = 1'b0;
  logic       host_reset, in_valid, in_ready, in_ad, host_busy;
  logic [7:0] in_data, host_data;
  logic       host_cs, host_ad, idle;
  logic [4:0] fifo_level;
`ifdef HOST_WR_OVF_EN
  logic       ovf;
`endif

  always #5 gen = ~gen;

  vga_host_writer #(.FIFO_DEPTH(16), .SETUP_LEN(2), .STROBE_LEN(4)) dut (
    .gen        (gen),
    .host_reset (host_reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ad      (in_ad),
    .in_data    (in_data),
    .host_busy  (host_busy),
    .host_cs    (host_cs),
    .host_ad    (host_ad),
    .host_data  (host_data),
    .fifo_level (fifo_level),
    .idle       (idle)
`ifdef HOST_WR_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, req);
    end
  endtask

  // Strobe monitor: records value, low width and stability of every strobe.
  logic [8:0] got_q[$];
  int         w_q[$];
  bit         s_q[$];
  int         rise_cyc[$];
  logic [8:0] expq[$];
  logic       prev_cs = 1'b1;
  logic [8:0] cur = '0;
  bit         stable = 1'b1;
  int         width = 0;
  int         cyc = 0;

  always @(negedge gen) begin
    cyc++;
    if (host_reset) begin
      prev_cs = 1'b1;
      width   = 0;
    end else begin
      if (!host_cs) begin
        if (prev_cs) begin
          cur    = {host_ad, host_data};
          stable = 1'b1;
          width  = 0;
        end else if ({host_ad, host_data} !== cur) begin
          stable = 1'b0;
        end
        width++;
      end else if (!prev_cs) begin
        if ({host_ad, host_data} !== cur) stable = 1'b0;
        got_q.push_back(cur);
        w_q.push_back(width);
        s_q.push_back(stable);
        rise_cyc.push_back(cyc);
      end
      prev_cs = host_cs;
    end
  end

  task automatic tick();
    @(posedge gen);
    #1;
  endtask

  task automatic push(input logic ad, input logic [7:0] d);
    in_valid = 1'b1;
    in_ad    = ad;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    expq.push_back({ad, d});
  endtask

  // Wait for every expected strobe, then compare order, width and stability.
  task automatic drain(input int exp_w);
    int n;
    n = 0;
    while (got_q.size() < expq.size() && n < 600) begin
      tick();
      n++;
    end
    check("drain_count", got_q.size(), expq.size());
    check("idle_after", idle, 1'b1);
    while (expq.size() > 0 && got_q.size() > 0) begin
      check("strobe_val", got_q.pop_front(), expq.pop_front());
      check("strobe_width", w_q.pop_front(), exp_w);
      check("strobe_stable", s_q.pop_front(), 1'b1);
    end
    expq.delete();
    repeat (12) tick();
    check("no_extra_strobe", got_q.size(), 0);
    got_q.delete();
    w_q.delete();
    s_q.delete();
  endtask

  // Advance until a sampled rising edge of host_cs (i.e. inside HOLD).
  task automatic wait_hold(output bit seen);
    logic p;
    int   n;
    p = host_cs;
    n = 0;
    while (!(p == 1'b0 && host_cs == 1'b1) && n < 200) begin
      p = host_cs;
      tick();
      n++;
    end
    seen = (n < 200);
  endtask

  initial begin
    int n;
    bit seen;

    host_reset = 1'b1;
    in_valid   = 1'b0;
    in_ad      = 1'b0;
    in_data    = '0;
    host_busy  = 1'b0;
    repeat (3) tick();
    host_reset = 1'b0;
    tick();

    // Reset state
    check("rst_cs", host_cs, 1'b1);
    check("rst_ad", host_ad, 1'b0);
    check("rst_data", host_data, 8'h00);
    check("rst_level", fifo_level, 5'd0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_idle", idle, 1'b1);
`ifdef HOST_WR_OVF_EN
    check("rst_ovf", ovf, 1'b0);
`endif

    // Two bytes, idle bus: latency, order, width, throughput
    rise_cyc.delete();
    push(1'b1, 8'h85);
    push(1'b0, 8'h41);
    n = 1;
    while (host_cs && n < 20) begin
      tick();
      n++;
    end
    check("latency", n + 1, 4);
    drain(4);
    check("rise_count", rise_cyc.size(), 2);
    if (rise_cyc.size() >= 2) check("throughput", rise_cyc[1] - rise_cyc[0], 8);

    // Fill to 16 while busy, refuse the 17th, push during HOLD pop refused
    host_busy = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) push(1'(i), 8'(i * 17 + 3));
    check("full_level", fifo_level, 5'd16);
    check("full_ready", in_ready, 1'b0);
    check("full_cs", host_cs, 1'b1);
    check("full_no_strobe", got_q.size(), 0);
    in_valid = 1'b1;
    in_ad    = 1'b0;
    in_data  = 8'hAA;
    tick();
    check("refused_level", fifo_level, 5'd16);
`ifdef HOST_WR_OVF_EN
    check("ovf_set", ovf, 1'b1);
`endif
    host_busy = 1'b0;
    wait_hold(seen);
    check("hold_seen_full", seen, 1'b1);
    check("level_in_hold", fifo_level, 5'd16);
    tick();
    in_valid = 1'b0;
    check("level_after_hold", fifo_level, 5'd15);
    check("ready_after_hold", in_ready, 1'b1);
    drain(4);
`ifdef HOST_WR_OVF_EN
    check("ovf_sticky", ovf, 1'b1);
`endif

    // busy raised on 2nd strobe cycle for 50 cycles: stretched strobe
    push(1'b0, 8'hC3);
    n = 0;
    while (host_cs && n < 20) begin
      tick();
      n++;
    end
    check("stall_cs_fell", host_cs, 1'b0);
    tick();
    host_busy = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("stall_cs_low", host_cs, 1'b0);
    end
    host_busy = 1'b0;
    drain(57);

    // busy raised during SETUP: no strobe, entry kept
    push(1'b1, 8'hE7);
    host_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("setup_abort_cs", host_cs, 1'b1);
    end
    check("setup_abort_level", fifo_level, 5'd1);
    check("setup_abort_nostrobe", got_q.size(), 0);
    host_busy = 1'b0;
    drain(4);

    // Half full: push during the HOLD pop keeps the level
    host_busy = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) push(1'b0, 8'(8'h30 + i));
    check("half_level", fifo_level, 5'd8);
    host_busy = 1'b0;
    wait_hold(seen);
    check("hold_seen_half", seen, 1'b1);
    check("half_level_hold", fifo_level, 5'd8);
    in_valid = 1'b1;
    in_ad    = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_valid = 1'b0;
    expq.push_back({1'b1, 8'h5A});
    check("push_pop_level", fifo_level, 5'd8);
    drain(4);

    // Reset while host_cs is low
    push(1'b1, 8'h11);
    push(1'b0, 8'h22);
    n = 0;
    while (host_cs && n < 20) begin
      tick();
      n++;
    end
    check("pre_rst_cs_low", host_cs, 1'b0);
    #2 host_reset = 1'b1;
    #1;
    check("mid_rst_cs", host_cs, 1'b1);
    check("mid_rst_level", fifo_level, 5'd0);
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_rst_idle", idle, 1'b1);
`ifdef HOST_WR_OVF_EN
    check("mid_rst_ovf", ovf, 1'b0);
`endif
    tick();
    host_reset = 1'b0;
    expq.delete();
    got_q.delete();
    w_q.delete();
    s_q.delete();
    repeat (20) tick();
    check("post_rst_nostrobe", got_q.size(), 0);
    check("post_rst_cs", host_cs, 1'b1);
    check("post_rst_level", fifo_level, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_host_writer.md
# vga_host_writer

Buffered host-bus master placed directly upstream of the text-mode VGA controller. It accepts address/command and data bytes from the system side, queues them in a FIFO, and replays each byte as one `host_cs` strobe cycle on the controller's 8-bit host bus. Strobes are issued only while the controller deasserts `host_busy`, which happens during vertical blanking. A strobe that the controller's `host_busy` interrupts is stretched, never cut short, so the controller's auto-incrementing RAM address stays consistent with the bytes actually written.

## Interface
- `FIFO_DEPTH`, 16: queue entries; must be a power of 2, minimum 2.
- `SETUP_LEN`, 2: cycles `host_ad`/`host_data` are stable with `host_cs` high before the strobe; minimum 1.
- `STROBE_LEN`, 4: cycles `host_cs` is held low; minimum 2.
- `gen`  in  1  pixel clock, same net as the controller's; this block uses the rising edge.
- `host_reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  system byte offered.
- `in_ready`  out  1  FIFO not full; a byte is accepted on a rising edge with `in_valid && in_ready`.
- `in_ad`  in  1  1 = address/command byte, 0 = data byte.
- `in_data`  in  8  byte payload.
- `host_busy`  in  1  controller busy (active display); 1 = no host access.
- `host_cs`  out  1  host strobe, active low; the controller captures on its rising edge.
- `host_ad`  out  1  copy of the queued `in_ad`.
- `host_data`  out  8  copy of the queued `in_data`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of queued entries.
- `idle`  out  1  FIFO empty and FSM in IDLE.
- `ovf`  out  1  sticky overflow flag; present only with `HOST_WR_OVF_EN`.

## Operation
- FIFO
  - 9 bits wide: `{ad, data}`.
  - Read and write pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally.
  - `in_ready = (fifo_level != FIFO_DEPTH)`, combinational from registered state.
  - When full, a push is refused even if a pop happens in the same cycle.
  - When neither full nor empty, simultaneous push and pop leaves `fifo_level` unchanged.
- FSM states and transitions
  - IDLE: if the FIFO is non-empty and the registered `host_busy` is 0, load the head entry into `host_ad`/`host_data` and go to SETUP. The entry is not popped yet.
  - SETUP: count `SETUP_LEN` cycles, then go to STROBE and drive `host_cs`=0. If `host_busy` rises during SETUP, return to IDLE with no strobe issued and the entry kept.
  - STROBE: count `STROBE_LEN` cycles with `host_cs` low. If `host_busy` rises, go to STALL.
  - STALL: hold `host_cs` low and freeze `host_ad`/`host_data`. When `host_busy` falls, restart STROBE with a full `STROBE_LEN` count.
  - HOLD: `host_cs`=1 (this is the capture edge) and `host_ad`/`host_data` are held for 1 cycle. Pop the entry, then go to IDLE.
- Every queued byte produces exactly one `host_cs` rising edge, delivered in FIFO order.
- `host_ad`/`host_data` change only while in IDLE, never while `host_cs` is low or during the HOLD cycle.
- `host_busy` is registered once on the `gen` rising edge before use. The controller updates it on the falling edge, so no synchronizer is needed.
- Reset values: `host_cs`=1, `host_ad`=0, `host_data`=0, FIFO empty, `fifo_level`=0, `in_ready`=1, `idle`=1, FSM in IDLE, `ovf`=0.
- Reset asserted mid-strobe:
  - `host_cs` returns to 1 asynchronously and the queue is discarded.
  - That rising edge may be captured by the controller. This is accepted; system software re-sends the address byte after any reset.

## Timing
- Latency from a byte pushed into an empty FIFO while `host_busy`=0 to the `host_cs` falling edge: 1 (push) + 1 (IDLE) + `SETUP_LEN` cycles = 4 cycles at defaults.
- Throughput with `host_busy`=0: one byte per `SETUP_LEN + STROBE_LEN + 2` cycles = 8 cycles at defaults.
- The `host_cs` low width is never shorter than `STROBE_LEN` contiguous cycles with `host_busy`=0 immediately before the rising edge.
- `idle` is registered and asserts 1 cycle after the final HOLD.

## Configuration
- `HOST_WR_OVF_EN` defined:
  - `ovf` port exists.
  - `ovf` sets on any cycle with `in_valid && !in_ready` and clears only on reset.
- `HOST_WR_OVF_EN` undefined:
  - No `ovf` port and no flag logic.
  - A refused push is silently ignored; the handshake behaviour is otherwise identical.

## Test plan
- Push `{ad=1, 0x85}` then `{ad=0, 0x41}` with `host_busy`=0 → two strobes, each 4 cycles low, data stable across each rising edge, in order; `idle`=1 after the second HOLD.
- Push 16 bytes with `host_busy`=1 → `fifo_level`=16, `in_ready`=0, `host_cs` stays 1.
  - Push a 17th byte → refused; with the macro, `ovf`=1.
  - Drop `host_busy` → 16 strobes, values in push order.
- Raise `host_busy` on the 2nd cycle of a strobe, hold it for 50 cycles → `host_cs` low for the entire stall, then 4 further low cycles after `host_busy` falls; exactly one rising edge in total.
- Raise `host_busy` during SETUP → no `host_cs` edge, entry retained, `fifo_level` unchanged; the strobe completes after `host_busy` falls.
- With the FIFO half full, push and pop in the same cycle → `fifo_level` constant.
  - With the FIFO full, push during a HOLD pop → push refused and `fifo_level` becomes 15.
- Assert `host_reset` with `host_cs` low → `host_cs`=1 in the same cycle, `fifo_level`=0, `in_ready`=1, `ovf`=0.
